// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream distributor with per-slot depth-1 buffers.
// A word is steered by Select, or broadcast, into independent valid/ready slots.
module demux_1to4_stream_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         free,
  output logic         nxt_valid
);

  // Draining and refilling in the same cycle keeps the slot full.
  always_comb begin
    free      = !valid || rdy;
    nxt_valid = wr || (valid && !rdy);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= nxt_valid;
      if (wr) data <= din;
    end
  end

endmodule

module demux_1to4_stream #(
  parameter int WidthOfInputs   = 32,
  parameter int NumberOfOutputs = 4
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic [WidthOfInputs-1:0] In,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [1:0]               Select,
  input  logic                     Broadcast,
  output logic [WidthOfInputs-1:0] Out_0,
  output logic [WidthOfInputs-1:0] Out_1,
  output logic [WidthOfInputs-1:0] Out_2,
  output logic [WidthOfInputs-1:0] Out_3,
  output logic                     Out_Valid_0,
  output logic                     Out_Valid_1,
  output logic                     Out_Valid_2,
  output logic                     Out_Valid_3,
  input  logic                     Out_Ready_0,
  input  logic                     Out_Ready_1,
  input  logic                     Out_Ready_2,
  input  logic                     Out_Ready_3,
  output logic                     Busy
);

  localparam int W = WidthOfInputs;

  if (NumberOfOutputs != 4) begin : g_bad_n
    $error("demux_1to4_stream: NumberOfOutputs must be 4");
  end

  logic [3:0]   rdy;
  logic [3:0]   free;
  logic [3:0]   vld;
  logic [3:0]   nxt_vld;
  logic [3:0]   wr;
  logic [W-1:0] data [4];
  logic         accept;
  logic         busy_q;

  assign rdy = {Out_Ready_3, Out_Ready_2,
                Out_Ready_1, Out_Ready_0};

  // Never depends on In_Valid.
  always_comb begin
    In_Ready = 1'b0;
    unique case (1'b1)
      Broadcast:  In_Ready = &free;
      !Broadcast: In_Ready = free[Select];
    endcase
  end

  assign accept = In_Valid && In_Ready;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    assign wr[k] = accept &&
                   (Broadcast || (Select == 2'(k)));

    demux_1to4_stream_slot #(.W(W)) u_slot (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .wr       (wr[k]),
      .din      (In),
      .rdy      (rdy[k]),
      .data     (data[k]),
      .valid    (vld[k]),
      .free     (free[k]),
      .nxt_valid(nxt_vld[k])
    );
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) busy_q <= 1'b0;
    else          busy_q <= |nxt_vld;
  end

  assign Busy        = busy_q;
  assign Out_0       = data[0];
  assign Out_1       = data[1];
  assign Out_2       = data[2];
  assign Out_3       = data[3];
  assign Out_Valid_0 = vld[0];
  assign Out_Valid_1 = vld[1];
  assign Out_Valid_2 = vld[2];
  assign Out_Valid_3 = vld[3];

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed self-checking bench for demux_1to4_stream.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_demux_1to4_stream;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] In;
  logic        In_Valid;
  logic        In_Ready;
  logic [1:0]  Select;
  logic        Broadcast;
  logic [31:0] Out_0, Out_1, Out_2, Out_3;
  logic        Out_Valid_0, Out_Valid_1;
  logic        Out_Valid_2, Out_Valid_3;
  logic        Out_Ready_0, Out_Ready_1;
  logic        Out_Ready_2, Out_Ready_3;
  logic        Busy;

  int n_cmp = 0;
  int n_err = 0;

  wire [3:0] vld = {Out_Valid_3, Out_Valid_2,
                    Out_Valid_1, Out_Valid_0};
  wire [127:0] outs = {Out_3, Out_2, Out_1, Out_0};

  always #5 Clock = ~Clock;

  demux_1to4_stream #(
    .WidthOfInputs  (32),
    .NumberOfOutputs(4)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .In         (In),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Select     (Select),
    .Broadcast  (Broadcast),
    .Out_0      (Out_0),
    .Out_1      (Out_1),
    .Out_2      (Out_2),
    .Out_3      (Out_3),
    .Out_Valid_0(Out_Valid_0),
    .Out_Valid_1(Out_Valid_1),
    .Out_Valid_2(Out_Valid_2),
    .Out_Valid_3(Out_Valid_3),
    .Out_Ready_0(Out_Ready_0),
    .Out_Ready_1(Out_Ready_1),
    .Out_Ready_2(Out_Ready_2),
    .Out_Ready_3(Out_Ready_3),
    .Busy       (Busy)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_rdy(input logic [3:0] r);
    {Out_Ready_3, Out_Ready_2,
     Out_Ready_1, Out_Ready_0} = r;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; In_Valid = 1'b1;
    In = 32'hFFFF_FFFF; Select = 2'd0;
    Broadcast = 1'b0; set_rdy(4'b0000);
    step(); step();
    n_cmp++;
    if (vld !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_vld got %b want %b", vld, 4'b0000);
    end
    n_cmp++;
    if (outs !== 128'h0) begin
      n_err++;
      $display("FAIL reset_out got %h want 0", outs);
    end
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got %b want 0", Busy);
    end
    In_Valid = 1'b0; Reset_n = 1'b1;
    step();
  endtask

  task automatic test_steer();
    set_rdy(4'b1111);
    In = 32'hA5; Select = 2'd2; In_Valid = 1'b1;
    #1;
    n_cmp++;
    if (In_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL steer_rdy got %b want 1", In_Ready);
    end
    step();
    In_Valid = 1'b0;
    n_cmp++;
    if (vld !== 4'b0100 || Out_2 !== 32'hA5) begin
      n_err++;
      $display("FAIL steer_out got %b/%h want 0100/a5",
               vld, Out_2);
    end
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL steer_busy1 got %b want 1", Busy);
    end
    step();
    n_cmp++;
    if (vld !== 4'b0000 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL steer_drain got %b/%b want 0000/0",
               vld, Busy);
    end
    n_cmp++;
    if (Out_2 !== 32'hA5) begin
      n_err++;
      $display("FAIL steer_hold got %h want a5", Out_2);
    end
  endtask

  task automatic test_back_to_back();
    set_rdy(4'b1111);
    Select = 2'd0; In_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      In = 32'hB0 + 32'(i);
      #1;
      n_cmp++;
      if (In_Ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_rdy%0d got %b want 1", i, In_Ready);
      end
      step();
      n_cmp++;
      if (Out_0 !== 32'hB0 + 32'(i) || vld !== 4'b0001) begin
        n_err++;
        $display("FAIL b2b_out%0d got %h/%b want %h/0001",
                 i, Out_0, vld, 32'hB0 + 32'(i));
      end
    end
    In_Valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    set_rdy(4'b1101);
    In = 32'h11; Select = 2'd1; In_Valid = 1'b1;
    step();
    In = 32'h22;
    #1;
    n_cmp++;
    if (Out_1 !== 32'h11 || vld !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_first got %h/%b want 11/0010",
               Out_1, vld);
    end
    n_cmp++;
    if (In_Ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_block got %b want 0", In_Ready);
    end
    step();
    n_cmp++;
    if (Out_1 !== 32'h11 || Out_Valid_1 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold got %h/%b want 11/1",
               Out_1, Out_Valid_1);
    end
    set_rdy(4'b1111);
    #1;
    n_cmp++;
    if (In_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_refill_rdy got %b want 1", In_Ready);
    end
    step();
    In_Valid = 1'b0;
    set_rdy(4'b1101);
    n_cmp++;
    if (Out_1 !== 32'h22 || Out_Valid_1 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_refill got %h/%b want 22/1",
               Out_1, Out_Valid_1);
    end
  endtask

  task automatic test_independence();
    In = 32'h33; Select = 2'd3; In_Valid = 1'b1;
    #1;
    n_cmp++;
    if (In_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL ind_rdy got %b want 1", In_Ready);
    end
    step();
    In_Valid = 1'b0;
    n_cmp++;
    if (Out_3 !== 32'h33 || vld !== 4'b1010) begin
      n_err++;
      $display("FAIL ind_out got %h/%b want 33/1010",
               Out_3, vld);
    end
    n_cmp++;
    if (Out_1 !== 32'h22) begin
      n_err++;
      $display("FAIL ind_keep got %h want 22", Out_1);
    end
    step();
    set_rdy(4'b1111);
    step();
  endtask

  task automatic test_broadcast();
    set_rdy(4'b1110);
    In = 32'h44; Select = 2'd0; In_Valid = 1'b1;
    step();
    In = 32'h77; Broadcast = 1'b1; Select = 2'd1;
    #1;
    n_cmp++;
    if (In_Ready !== 1'b0) begin
      n_err++;
      $display("FAIL bc_block got %b want 0", In_Ready);
    end
    step();
    n_cmp++;
    if (vld !== 4'b0001 || outs !==
        {32'h33, 32'hA5, 32'h22, 32'h44}) begin
      n_err++;
      $display("FAIL bc_nowrite got %b/%h want 0001/33 a5 22 44",
               vld, outs);
    end
    set_rdy(4'b1111);
    #1;
    n_cmp++;
    if (In_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL bc_rdy got %b want 1", In_Ready);
    end
    step();
    In_Valid = 1'b0; Broadcast = 1'b0;
    n_cmp++;
    if (vld !== 4'b1111 || outs !==
        {4{32'h77}}) begin
      n_err++;
      $display("FAIL bc_all got %b/%h want 1111/77x4",
               vld, outs);
    end
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL bc_busy got %b want 1", Busy);
    end
    step();
    n_cmp++;
    if (vld !== 4'b0000 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL bc_drain got %b/%b want 0000/0",
               vld, Busy);
    end
  endtask

  task automatic test_midreset();
    set_rdy(4'b1010);
    In = 32'h55; Select = 2'd0; In_Valid = 1'b1;
    step();
    In = 32'h66; Select = 2'd2;
    step();
    In = 32'h99; Select = 2'd1;
    #1;
    n_cmp++;
    if (vld !== 4'b0101 || In_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL mr_pre got %b/%b want 0101/1",
               vld, In_Ready);
    end
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1; In_Valid = 1'b0;
    n_cmp++;
    if (vld !== 4'b0000 || outs !== 128'h0 ||
        Busy !== 1'b0) begin
      n_err++;
      $display("FAIL mr_clear got %b/%h/%b want 0000/0/0",
               vld, outs, Busy);
    end
    step();
    n_cmp++;
    if (vld !== 4'b0000 || Out_1 !== 32'h0) begin
      n_err++;
      $display("FAIL mr_lost got %b/%h want 0000/0",
               vld, Out_1);
    end
  endtask

  initial begin
    test_reset();
    test_steer();
    test_back_to_back();
    test_backpressure();
    test_independence();
    test_broadcast();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
